// File: rtl/ll_rx_cred_ret_pkg.sv
// Shared credit definitions for the logic-link credit blocks (RX return and TX credit).
package ll_cred_pkg;

    localparam int         CRED_RET_W   = 4;
    localparam logic [7:0] DEFAULT_CRED = 8'd1;

    // Low-aligned thermometer encoding of a per-cycle credit return count (0..4).
    function automatic logic [CRED_RET_W-1:0] cred_therm(input logic [2:0] n);
        logic [CRED_RET_W-1:0] t;
        case (n)
            3'd0:    t = 4'b0000;
            3'd1:    t = 4'b0001;
            3'd2:    t = 4'b0011;
            3'd3:    t = 4'b0111;
            3'd4:    t = 4'b1111;
            default: t = 4'b1111;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/ll_rx_cred_ret_if.sv
// Link-side signal bundle of the RX credit return engine.
interface ll_rx_cred_ret_if;
    import ll_cred_pkg::*;

    logic                  rx_online;
    logic [7:0]            init_i_credit;
    logic                  rxfifo_i_push;
    logic                  rxfifo_i_pop;
    logic                  credit_ret_hold;
    logic [CRED_RET_W-1:0] tx_i_credit;
    logic                  rx_i_overflow;
    logic [7:0]            dbg_pending_i_credit;
    logic [7:0]            dbg_outstanding_i_credit;

    // Environment side: drives link state and FIFO events, observes credit returns.
    modport master (
        output rx_online, init_i_credit, rxfifo_i_push, rxfifo_i_pop, credit_ret_hold,
        input  tx_i_credit, rx_i_overflow, dbg_pending_i_credit, dbg_outstanding_i_credit
    );

    // Engine side.
    modport slave (
        input  rx_online, init_i_credit, rxfifo_i_push, rxfifo_i_pop, credit_ret_hold,
        output tx_i_credit, rx_i_overflow, dbg_pending_i_credit, dbg_outstanding_i_credit
    );
endinterface

// File: rtl/ll_rx_cred_ret_chk.sv
// Invariant checker: credits earned-but-unreturned plus credits held by the far
// end can never exceed what was granted when the link came online.
module ll_rx_cred_ret_chk #(
    parameter logic [7:0] DEFAULT_RX_CRED = 8'd1
) (
    input logic       clk,
    input logic       rst_n,
    input logic       rx_online,
    input logic [7:0] init_credit,
    input logic [7:0] pending,
    input logic [7:0] outstanding
);

    logic       act_r;
    logic [7:0] load_r;
    logic [8:0] sum_s;

    assign sum_s = {1'b0, pending} + {1'b0, outstanding};

    // Capture the grant loaded at the online rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_r  <= 1'b0;
            load_r <= 8'd0;
        end else if (!rx_online) begin
            act_r  <= 1'b0;
            load_r <= 8'd0;
        end else if (!act_r) begin
            act_r  <= 1'b1;
            load_r <= (init_credit != 8'd0) ? init_credit : DEFAULT_RX_CRED;
        end else begin
            act_r  <= act_r;
            load_r <= load_r;
        end
    end

    a_cred_conserved: assert property (@(posedge clk) disable iff (!rst_n)
        act_r |-> (sum_s <= {1'b0, load_r}));

endmodule

// File: rtl/ll_rx_cred_ret_unit_cnt.sv
// Divides FIFO entry events into credit units: unit_done pulses on every
// RX_CRED_SIZE-th event, in the same cycle as that event.
module ll_cred_unit_cnt #(
    parameter logic [2:0] RX_CRED_SIZE = 3'h1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic evt,
    output logic unit_done
);

    logic [2:0] cnt_r;
    logic       wrap_s;

    // Detect the event that completes a credit unit; size 1 (or illegal 0) makes every event a unit.
    always_comb begin
        wrap_s = 1'b0;
        if (RX_CRED_SIZE <= 3'd1) begin
            wrap_s = evt;
        end else if (evt && (cnt_r == (RX_CRED_SIZE - 3'd1))) begin
            wrap_s = 1'b1;
        end else begin
            wrap_s = 1'b0;
        end
    end

    assign unit_done = wrap_s & ~clr;

    // Entry counter within the current credit unit; cleared while the link is not active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 3'd0;
        end else if (clr) begin
            cnt_r <= 3'd0;
        end else if (wrap_s) begin
            cnt_r <= 3'd0;
        end else if (evt) begin
            cnt_r <= cnt_r + 3'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/ll_rx_cred_ret.sv
// Receive-side credit return engine for one logic-link channel: turns freed RX
// FIFO entries into credit-return bits and tracks the far end's credit balance.
module ll_rx_cred_ret
    import ll_cred_pkg::*;
#(
    parameter logic       ASYMMETRIC_CREDIT = 1'h1,
    parameter logic [2:0] RX_CRED_SIZE      = 3'h1,
    parameter logic [7:0] DEFAULT_RX_CRED   = DEFAULT_CRED
) (
    input logic            clk_wr,
    input logic            rst_wr_n,
    ll_rx_cred_ret_if.slave lnk
);

    logic                  online_dly_r;
    logic [7:0]            pending_r;
    logic [7:0]            outstanding_r;
    logic [CRED_RET_W-1:0] tx_credit_r;
    logic                  overflow_r;

    logic                  rise_s;
    logic                  clr_s;
    logic                  inc_s;
    logic                  dec_s;
    logic [2:0]            n_s;
    logic [8:0]            pend_sum_s;
    logic [8:0]            out_sum_s;
    logic [8:0]            out_dec_s;
    logic [7:0]            pending_nxt_s;
    logic [7:0]            outstanding_nxt_s;
    logic                  ovf_set_s;

    // The cycle of the online rising edge reloads state, so its FIFO events are discarded.
    assign rise_s = lnk.rx_online & ~online_dly_r;
    assign clr_s  = ~lnk.rx_online | rise_s;

    ll_cred_unit_cnt #(.RX_CRED_SIZE(RX_CRED_SIZE)) u_pop (
        .clk       (clk_wr),
        .rst_n     (rst_wr_n),
        .clr       (clr_s),
        .evt       (lnk.rxfifo_i_pop),
        .unit_done (inc_s)
    );

    ll_cred_unit_cnt #(.RX_CRED_SIZE(RX_CRED_SIZE)) u_push (
        .clk       (clk_wr),
        .rst_n     (rst_wr_n),
        .clr       (clr_s),
        .evt       (lnk.rxfifo_i_push),
        .unit_done (dec_s)
    );

    // Credits returned this cycle, drawn only from what was already pending.
    always_comb begin
        n_s = 3'd0;
        if (lnk.credit_ret_hold) begin
            n_s = 3'd0;
        end else if (ASYMMETRIC_CREDIT == 1'b1) begin
            if (pending_r >= 8'd4) begin
                n_s = 3'd4;
            end else begin
                n_s = pending_r[2:0];
            end
        end else begin
            if (pending_r != 8'd0) begin
                n_s = 3'd1;
            end else begin
                n_s = 3'd0;
            end
        end
    end

    // Next pending/outstanding balances with saturation and zero-credit push detection.
    always_comb begin
        pend_sum_s        = {1'b0, pending_r} + {8'd0, inc_s} - {6'd0, n_s};
        out_sum_s         = {1'b0, outstanding_r} + {6'd0, n_s};
        out_dec_s         = out_sum_s - 9'd1;
        pending_nxt_s     = pend_sum_s[8] ? 8'hFF : pend_sum_s[7:0];
        outstanding_nxt_s = out_sum_s[8] ? 8'hFF : out_sum_s[7:0];
        ovf_set_s         = 1'b0;
        if (dec_s) begin
            if (out_sum_s == 9'd0) begin
                ovf_set_s         = 1'b1;
                outstanding_nxt_s = 8'd0;
            end else begin
                outstanding_nxt_s = out_dec_s[8] ? 8'hFF : out_dec_s[7:0];
            end
        end else begin
            ovf_set_s = 1'b0;
        end
    end

    // Credit state: offline clears everything, the online edge loads the grant, otherwise update.
    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            online_dly_r  <= 1'b0;
            pending_r     <= 8'd0;
            outstanding_r <= 8'd0;
            tx_credit_r   <= 4'b0000;
            overflow_r    <= 1'b0;
        end else if (!lnk.rx_online) begin
            online_dly_r  <= 1'b0;
            pending_r     <= 8'd0;
            outstanding_r <= 8'd0;
            tx_credit_r   <= 4'b0000;
            overflow_r    <= 1'b0;
        end else if (rise_s) begin
            online_dly_r  <= 1'b1;
            pending_r     <= 8'd0;
            outstanding_r <= (lnk.init_i_credit != 8'd0) ? lnk.init_i_credit : DEFAULT_RX_CRED;
            tx_credit_r   <= 4'b0000;
            overflow_r    <= overflow_r;
        end else begin
            online_dly_r  <= 1'b1;
            pending_r     <= pending_nxt_s;
            outstanding_r <= outstanding_nxt_s;
            tx_credit_r   <= cred_therm(n_s);
            overflow_r    <= overflow_r | ovf_set_s;
        end
    end

    assign lnk.tx_i_credit              = tx_credit_r;
    assign lnk.rx_i_overflow            = overflow_r;
    assign lnk.dbg_pending_i_credit     = pending_r;
    assign lnk.dbg_outstanding_i_credit = outstanding_r;

    ll_rx_cred_ret_chk #(.DEFAULT_RX_CRED(DEFAULT_RX_CRED)) u_chk (
        .clk         (clk_wr),
        .rst_n       (rst_wr_n),
        .rx_online   (lnk.rx_online),
        .init_credit (lnk.init_i_credit),
        .pending     (pending_r),
        .outstanding (outstanding_r)
    );

endmodule

// File: tb/tb_ll_rx_cred_ret.sv
// Scoreboard bench for ll_rx_cred_ret: three configurations (asym/size1,
// asym/size4, sym/size1) driven with directed FIFO event sequences.
module tb_ll_rx_cred_ret;
    import ll_cred_pkg::*;

    logic clk_wr = 1'b0;
    logic rst_wr_n;

    always #5 clk_wr = ~clk_wr;

    ll_rx_cred_ret_if ifa ();
    ll_rx_cred_ret_if ifb ();
    ll_rx_cred_ret_if ifc ();

    ll_rx_cred_ret #(.ASYMMETRIC_CREDIT(1'b1), .RX_CRED_SIZE(3'd1), .DEFAULT_RX_CRED(8'd1)) u_a (
        .clk_wr(clk_wr), .rst_wr_n(rst_wr_n), .lnk(ifa.slave));
    ll_rx_cred_ret #(.ASYMMETRIC_CREDIT(1'b1), .RX_CRED_SIZE(3'd4), .DEFAULT_RX_CRED(8'd1)) u_b (
        .clk_wr(clk_wr), .rst_wr_n(rst_wr_n), .lnk(ifb.slave));
    ll_rx_cred_ret #(.ASYMMETRIC_CREDIT(1'b0), .RX_CRED_SIZE(3'd1), .DEFAULT_RX_CRED(8'd1)) u_c (
        .clk_wr(clk_wr), .rst_wr_n(rst_wr_n), .lnk(ifc.slave));

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [3:0] qa[$];
    logic [3:0] qb[$];
    logic [3:0] qc[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_wr);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_wr_n = 1'b0;
        ifa.rx_online = 1'b0; ifa.init_i_credit = 8'd0; ifa.rxfifo_i_push = 1'b0;
        ifa.rxfifo_i_pop = 1'b0; ifa.credit_ret_hold = 1'b0;
        ifb.rx_online = 1'b0; ifb.init_i_credit = 8'd0; ifb.rxfifo_i_push = 1'b0;
        ifb.rxfifo_i_pop = 1'b0; ifb.credit_ret_hold = 1'b0;
        ifc.rx_online = 1'b0; ifc.init_i_credit = 8'd0; ifc.rxfifo_i_push = 1'b0;
        ifc.rxfifo_i_pop = 1'b0; ifc.credit_ret_hold = 1'b0;

        // Monitor: every nonzero credit-return word must match the next expected one.
        fork
            forever begin
                @(negedge clk_wr);
                if (rst_wr_n === 1'b1) begin
                    if (ifa.tx_i_credit !== 4'd0) begin
                        if (qa.size() == 0) chk("a_tx_unexpected", ifa.tx_i_credit, 0);
                        else chk("a_tx", ifa.tx_i_credit, qa.pop_front());
                    end
                    if (ifb.tx_i_credit !== 4'd0) begin
                        if (qb.size() == 0) chk("b_tx_unexpected", ifb.tx_i_credit, 0);
                        else chk("b_tx", ifb.tx_i_credit, qb.pop_front());
                    end
                    if (ifc.tx_i_credit !== 4'd0) begin
                        if (qc.size() == 0) chk("c_tx_unexpected", ifc.tx_i_credit, 0);
                        else chk("c_tx", ifc.tx_i_credit, qc.pop_front());
                    end
                end
            end
        join_none

        // Reset state
        #12;
        chk("rst_a_tx", ifa.tx_i_credit, 0);
        chk("rst_a_ovf", ifa.rx_i_overflow, 0);
        chk("rst_a_pend", ifa.dbg_pending_i_credit, 0);
        chk("rst_a_out", ifa.dbg_outstanding_i_credit, 0);
        chk("rst_b_out", ifb.dbg_outstanding_i_credit, 0);
        chk("rst_c_tx", ifc.tx_i_credit, 0);
        tick(1);
        rst_wr_n = 1'b1;
        tick(1);

        // 1: init=8, 3 pushes then 3 pops -> three 0001 returns, 2-edge latency
        ifa.init_i_credit = 8'd8; ifa.rx_online = 1'b1;
        tick(1);
        chk("t1_load", ifa.dbg_outstanding_i_credit, 8);
        chk("t1_pend0", ifa.dbg_pending_i_credit, 0);
        ifa.rxfifo_i_push = 1'b1;
        tick(3);
        ifa.rxfifo_i_push = 1'b0;
        chk("t1_out_after_push", ifa.dbg_outstanding_i_credit, 5);
        repeat (3) qa.push_back(4'b0001);
        ifa.rxfifo_i_pop = 1'b1;
        tick(1);
        chk("t1_lat_tx0", ifa.tx_i_credit, 0);
        chk("t1_lat_pend1", ifa.dbg_pending_i_credit, 1);
        tick(1);
        chk("t1_lat_tx1", ifa.tx_i_credit, 1);
        tick(1);
        ifa.rxfifo_i_pop = 1'b0;
        tick(2);
        chk("t1_tx_idle", ifa.tx_i_credit, 0);
        chk("t1_pend_end", ifa.dbg_pending_i_credit, 0);
        chk("t1_out_end", ifa.dbg_outstanding_i_credit, 8);

        // 2: pending 6 under hold, then release -> 1111, 0011
        ifa.rxfifo_i_push = 1'b1;
        tick(6);
        ifa.rxfifo_i_push = 1'b0;
        ifa.credit_ret_hold = 1'b1;
        ifa.rxfifo_i_pop = 1'b1;
        tick(6);
        ifa.rxfifo_i_pop = 1'b0;
        tick(2);
        chk("t2_hold_tx", ifa.tx_i_credit, 0);
        chk("t2_hold_pend", ifa.dbg_pending_i_credit, 6);
        chk("t2_hold_out", ifa.dbg_outstanding_i_credit, 2);
        qa.push_back(4'b1111);
        qa.push_back(4'b0011);
        ifa.credit_ret_hold = 1'b0;
        tick(1);
        chk("t2_pend_mid", ifa.dbg_pending_i_credit, 2);
        tick(1);
        chk("t2_tx_last", ifa.tx_i_credit, 4'b0011);
        chk("t2_pend_end", ifa.dbg_pending_i_credit, 0);
        chk("t2_out_end", ifa.dbg_outstanding_i_credit, 8);
        tick(1);

        // 5: init=2, three pushes without returns -> overflow on the third
        ifa.rx_online = 1'b0;
        tick(1);
        ifa.init_i_credit = 8'd2; ifa.rx_online = 1'b1;
        tick(1);
        chk("t5_load", ifa.dbg_outstanding_i_credit, 2);
        ifa.credit_ret_hold = 1'b1;
        ifa.rxfifo_i_push = 1'b1;
        tick(2);
        chk("t5_ovf_early", ifa.rx_i_overflow, 0);
        chk("t5_out_zero", ifa.dbg_outstanding_i_credit, 0);
        tick(1);
        ifa.rxfifo_i_push = 1'b0;
        chk("t5_ovf_set", ifa.rx_i_overflow, 1);
        chk("t5_out_nowrap", ifa.dbg_outstanding_i_credit, 0);
        tick(2);
        chk("t5_ovf_sticky", ifa.rx_i_overflow, 1);
        ifa.rx_online = 1'b0;
        ifa.credit_ret_hold = 1'b0;
        tick(1);
        chk("t5_off_ovf", ifa.rx_i_overflow, 0);
        chk("t5_off_tx", ifa.tx_i_credit, 0);
        chk("t5_off_pend", ifa.dbg_pending_i_credit, 0);
        chk("t5_off_out", ifa.dbg_outstanding_i_credit, 0);

        // 6: init=0 loads the default; async reset mid-return
        ifa.init_i_credit = 8'd0; ifa.rx_online = 1'b1;
        tick(1);
        chk("t6_default", ifa.dbg_outstanding_i_credit, 1);
        ifa.rxfifo_i_push = 1'b1;
        tick(1);
        ifa.rxfifo_i_push = 1'b0;
        ifa.rxfifo_i_pop = 1'b1;
        tick(1);
        ifa.rxfifo_i_pop = 1'b0;
        tick(1);
        chk("t6_pre_rst_tx", ifa.tx_i_credit, 1);
        rst_wr_n = 1'b0;
        #1;
        chk("t6_rst_tx", ifa.tx_i_credit, 0);
        chk("t6_rst_pend", ifa.dbg_pending_i_credit, 0);
        chk("t6_rst_out", ifa.dbg_outstanding_i_credit, 0);
        chk("t6_rst_ovf", ifa.rx_i_overflow, 0);
        ifa.rx_online = 1'b0;
        tick(1);
        rst_wr_n = 1'b1;
        tick(1);

        // 3: RX_CRED_SIZE=4 -> 7 pops return 1 credit, 8th pop returns the second
        ifb.init_i_credit = 8'd8; ifb.rx_online = 1'b1;
        tick(1);
        ifb.rxfifo_i_push = 1'b1;
        tick(8);
        ifb.rxfifo_i_push = 1'b0;
        chk("t3_out_push", ifb.dbg_outstanding_i_credit, 6);
        chk("t3_push_cnt", u_b.u_push.cnt_r, 0);
        qb.push_back(4'b0001);
        ifb.rxfifo_i_pop = 1'b1;
        tick(7);
        ifb.rxfifo_i_pop = 1'b0;
        tick(3);
        chk("t3_out_7pop", ifb.dbg_outstanding_i_credit, 7);
        chk("t3_pend_7pop", ifb.dbg_pending_i_credit, 0);
        chk("t3_cnt_7pop", u_b.u_pop.cnt_r, 3);
        qb.push_back(4'b0001);
        ifb.rxfifo_i_pop = 1'b1;
        tick(1);
        ifb.rxfifo_i_pop = 1'b0;
        chk("t3_pend_8pop", ifb.dbg_pending_i_credit, 1);
        tick(3);
        chk("t3_out_8pop", ifb.dbg_outstanding_i_credit, 8);
        chk("t3_cnt_8pop", u_b.u_pop.cnt_r, 0);

        // 4: symmetric, pending 3 -> 0001 on three cycles only
        ifc.init_i_credit = 8'd8; ifc.rx_online = 1'b1;
        tick(1);
        ifc.rxfifo_i_push = 1'b1;
        tick(3);
        ifc.rxfifo_i_push = 1'b0;
        ifc.credit_ret_hold = 1'b1;
        ifc.rxfifo_i_pop = 1'b1;
        tick(3);
        ifc.rxfifo_i_pop = 1'b0;
        chk("t4_pend3", ifc.dbg_pending_i_credit, 3);
        repeat (3) qc.push_back(4'b0001);
        ifc.credit_ret_hold = 1'b0;
        tick(1);
        chk("t4_pend2", ifc.dbg_pending_i_credit, 2);
        tick(3);
        chk("t4_tx_idle", ifc.tx_i_credit, 0);
        chk("t4_pend_end", ifc.dbg_pending_i_credit, 0);
        chk("t4_out_end", ifc.dbg_outstanding_i_credit, 8);

        tick(3);
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        chk("qc_drained", qc.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ll_rx_cred_ret.md
Name: ll_rx_cred_ret

Overview:
Receive-side credit return engine for one logic link channel. Counts RX FIFO entries freed by the local consumer, converts them to credit units, and emits per-cycle credit-return bits on the line. Those bits are the far-end transmitter's `rx_i_credit`. The block also tracks credits outstanding at the far end and flags any push that arrives without a credit.

Parameters:
- ASYMMETRIC_CREDIT, 1'h1: 1 = up to 4 credits returned per cycle; 0 = at most 1 per cycle, bit 0 only.
- RX_CRED_SIZE, 3'h1: FIFO entries per credit, legal range 1..7.
- DEFAULT_RX_CRED, 8'd01: outstanding credit loaded when `init_i_credit` is 0.

Ports:
- clk_wr  in  1  clock
- rst_wr_n  in  1  async active-low reset
- rx_online  in  1  link online; low clears all state
- init_i_credit  in  8  credits granted to far end at online
- rxfifo_i_push  in  1  one entry written into RX FIFO from line
- rxfifo_i_pop  in  1  one entry popped by local consumer
- credit_ret_hold  in  1  packetizer cannot carry credit bits this cycle
- tx_i_credit  out  4  credit-return bits, low-aligned thermometer (0000/0001/0011/0111/1111)
- rx_i_overflow  out  1  sticky: push received with zero outstanding credit
- dbg_pending_i_credit  out  8  credits earned, not yet returned
- dbg_outstanding_i_credit  out  8  credits far end currently holds

Behaviour:
- Reset values: all outputs 0; pending=0, outstanding=0, both unit counters=0, online_dly=0.
- rx_online==0, checked each cycle with priority over all else:
  - pending, outstanding, unit counters, tx_i_credit and rx_i_overflow clear to 0 next edge.
- Online rising edge (rx_online & !online_dly):
  - outstanding loads init_i_credit, or DEFAULT_RX_CRED if init_i_credit is 0.
  - pending=0, counters=0, tx_i_credit=0.
  - push/pop in that cycle are ignored.
- Pop unit counter:
  - Increments on rxfifo_i_pop.
  - When counter==RX_CRED_SIZE-1 and pop is high: counter returns to 0 and inc=1 for that cycle.
  - RX_CRED_SIZE=1 gives inc=pop.
- Push unit counter: identical structure, driven by rxfifo_i_push, produces dec.
- Return count n, computed in cycle C from pending_reg only (excludes this cycle's inc):
  - n=0 if credit_ret_hold.
  - Otherwise n=min(pending_reg, 4) if ASYMMETRIC_CREDIT, else min(pending_reg, 1).
- Update edge:
  - tx_i_credit <= thermometer(n).
  - pending <= pending + inc - n.
  - outstanding <= outstanding + n - dec.
- Latency: pop sampled at edge E → pending=1 after E → tx_i_credit=0001 after E+1 (2 edges). Hold stalls return without losing credit.
- Simultaneous inc and n: both applied the same edge. Simultaneous n and dec: net arithmetic.
- Overflow: dec while (outstanding + n)==0 → rx_i_overflow <= 1 and outstanding stays 0 (no wrap). Sticky until rx_online low or reset.
- Saturation: pending saturates at 8'hFF; an inc at FF is dropped. Outstanding saturates at 8'hFF.
- Width rule: all credit arithmetic is 8-bit unsigned with an explicit 9-bit intermediate for saturation checks.
- Invariant, checked by assertion: pending + outstanding never exceeds the initial load value.
- Reset mid-operation: async clear of everything, immediately.

Decomposition:
- Package ll_cred_pkg:
  - Constant CRED_RET_W=4.
  - Function cred_therm(n[2:0]) returning [3:0].
  - Constant DEFAULT_CRED=8'd1 (shared with the TX credit block).
- Sub-module ll_cred_unit_cnt (param RX_CRED_SIZE; in event; out unit_done), instantiated twice: pop side and push side.

Test Plan:
- Online with init=8, RX_CRED_SIZE=1, asym: pop 3 in one burst cycle-by-cycle → tx_i_credit 0001 on 3 consecutive cycles starting 2 edges after first pop; outstanding ends 8.
- Pending=6 built with credit_ret_hold=1 and tx_i_credit=0000 → release hold → tx_i_credit 1111 then 0011; pending 0; outstanding +6.
- RX_CRED_SIZE=4: 7 pops → exactly 1 credit returned; 8th pop → second credit returned; unit counter back to 0.
- ASYMMETRIC_CREDIT=0, pending=3 → tx_i_credit 0001 three cycles, never bit[3:1] set.
- init=2: 3 pushes with no returns → rx_i_overflow=1 on 3rd push edge, outstanding=0. Then drop rx_online → overflow, counters and tx_i_credit all 0.
- init_i_credit=0 → outstanding=1 after online edge. Assert rst_wr_n low mid-burst → all outputs 0 asynchronously.
